// File: rtl/compc_pkg.sv
// Shared types and constants for the two-requester compc arbiter.
package compc_pkg;

    localparam int DATA_W_DEFAULT = 8;
    localparam int BURST_CNT_W    = 4;
    localparam int XFER_CNT_W     = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } owner_e;

    // Ownership state for a given requester id.
    function automatic owner_e own_state(input logic id);
        return id ? OWN1 : OWN0;
    endfunction

endpackage

// File: rtl/compc_arbiter_if.sv
// Requester, output and status signals of the compc arbiter.
// The master side drives operands and out_ready; the slave side is the arbiter.
interface compc_arbiter_if #(
    parameter int DATA_W = compc_pkg::DATA_W_DEFAULT
);
    import compc_pkg::*;

    logic              req0_valid;
    logic              req0_ready;
    logic [DATA_W-1:0] req0_a;
    logic [DATA_W-1:0] req0_b;

    logic              req1_valid;
    logic              req1_ready;
    logic [DATA_W-1:0] req1_a;
    logic [DATA_W-1:0] req1_b;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_x;
    logic [DATA_W-1:0] out_y;
    logic              out_id;

    logic [XFER_CNT_W-1:0] xfer_count;

    modport master (
        output req0_valid, req0_a, req0_b,
        output req1_valid, req1_a, req1_b,
        output out_ready,
        input  req0_ready, req1_ready,
        input  out_valid, out_x, out_y, out_id, xfer_count
    );

    modport slave (
        input  req0_valid, req0_a, req0_b,
        input  req1_valid, req1_a, req1_b,
        input  out_ready,
        output req0_ready, req1_ready,
        output out_valid, out_x, out_y, out_id, xfer_count
    );

endinterface

// File: rtl/compc_out_reg.sv
// One-entry valid/ready output register holding {id, x, y}.
module compc_out_reg #(
    parameter int DATA_W = compc_pkg::DATA_W_DEFAULT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load_en,
    input  logic              ld_id,
    input  logic [DATA_W-1:0] ld_x,
    input  logic [DATA_W-1:0] ld_y,
    input  logic              out_ready,
    output logic              out_valid,
    output logic              out_id,
    output logic [DATA_W-1:0] out_x,
    output logic [DATA_W-1:0] out_y
);

    logic              valid_q, valid_d;
    logic              id_q, id_d;
    logic [DATA_W-1:0] x_q, x_d;
    logic [DATA_W-1:0] y_q, y_d;

    // Next contents: a new load wins over a drain; a drain keeps the data.
    always_comb begin
        valid_d = valid_q;
        id_d    = id_q;
        x_d     = x_q;
        y_d     = y_q;
        if (load_en) begin
            valid_d = 1'b1;
            id_d    = ld_id;
            x_d     = ld_x;
            y_d     = ld_y;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    // Register with asynchronous clear; a held result is discarded on reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            id_q    <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            valid_q <= valid_d;
            id_q    <= id_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

    assign out_valid = valid_q;
    assign out_id    = id_q;
    assign out_x     = x_q;
    assign out_y     = y_q;

endmodule

// File: rtl/compc_arbiter.sv
// Two-requester burst-bounded arbiter in front of a registered a->x, b->y datapath.
module compc_arbiter
    import compc_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEFAULT,
    parameter int MAX_BURST = 4
) (
    input  logic           clock,
    input  logic           reset,
    compc_arbiter_if.slave bus
);

    localparam logic [BURST_CNT_W-1:0] MAX_CNT = BURST_CNT_W'(MAX_BURST);

    owner_e                  state_q, state_d;
    logic [BURST_CNT_W-1:0]  burst_cnt_q, burst_cnt_d;
    logic                    rr_ptr_q, rr_ptr_d;
    logic [XFER_CNT_W-1:0]   xfer_count_q, xfer_count_d;

    logic              v0, v1;
    logic              own_id, own_v, oth_v;
    logic              grant_vld, grant_id;
    logic              load, fire;
    logic              out_valid;
    logic              out_id;
    logic [DATA_W-1:0] out_x, out_y;
    logic [DATA_W-1:0] ld_x, ld_y;

    assign v0     = bus.req0_valid;
    assign v1     = bus.req1_valid;
    assign own_id = (state_q == OWN1);
    assign own_v  = own_id ? v1 : v0;
    assign oth_v  = own_id ? v0 : v1;

    // Pick the winner: round-robin from idle, otherwise stay with the owner
    // until its burst budget is spent while the other side waits.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = 1'b0;
        if (state_q == IDLE) begin
            if (v0 && v1) begin
                grant_vld = 1'b1;
                grant_id  = rr_ptr_q;
            end else if (v0 || v1) begin
                grant_vld = 1'b1;
                grant_id  = v1;
            end
        end else if (own_v && ((burst_cnt_q < MAX_CNT) || !oth_v)) begin
            grant_vld = 1'b1;
            grant_id  = own_id;
        end else if (oth_v) begin
            grant_vld = 1'b1;
            grant_id  = !own_id;
        end
    end

    assign load = !out_valid || bus.out_ready;
    assign fire = load && grant_vld;

    assign bus.req0_ready = !reset && fire && !grant_id;
    assign bus.req1_ready = !reset && fire && grant_id;

    // Ownership, burst count and round-robin pointer advance only on load cycles.
    always_comb begin
        state_d     = state_q;
        burst_cnt_d = burst_cnt_q;
        rr_ptr_d    = rr_ptr_q;
        if (load) begin
            if (grant_vld) begin
                state_d = own_state(grant_id);
                if ((state_q != IDLE) && (grant_id == own_id)) begin
                    burst_cnt_d = (burst_cnt_q >= MAX_CNT) ? MAX_CNT
                                                           : burst_cnt_q + BURST_CNT_W'(1);
                end else begin
                    burst_cnt_d = BURST_CNT_W'(1);
                end
            end else if (state_q != IDLE) begin
                state_d     = IDLE;
                burst_cnt_d = '0;
                rr_ptr_d    = !own_id;
            end
        end
    end

    // Count completed output transfers, wrapping naturally.
    always_comb begin
        xfer_count_d = xfer_count_q + XFER_CNT_W'(out_valid && bus.out_ready);
    end

    // Arbiter state and transfer counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            burst_cnt_q  <= '0;
            rr_ptr_q     <= 1'b0;
            xfer_count_q <= '0;
        end else begin
            state_q      <= state_d;
            burst_cnt_q  <= burst_cnt_d;
            rr_ptr_q     <= rr_ptr_d;
            xfer_count_q <= xfer_count_d;
        end
    end

    assign ld_x = grant_id ? bus.req1_a : bus.req0_a;
    assign ld_y = grant_id ? bus.req1_b : bus.req0_b;

    compc_out_reg #(
        .DATA_W (DATA_W)
    ) u_out_reg (
        .clock     (clock),
        .reset     (reset),
        .load_en   (fire),
        .ld_id     (grant_id),
        .ld_x      (ld_x),
        .ld_y      (ld_y),
        .out_ready (bus.out_ready),
        .out_valid (out_valid),
        .out_id    (out_id),
        .out_x     (out_x),
        .out_y     (out_y)
    );

    assign bus.out_valid  = out_valid;
    assign bus.out_id     = out_id;
    assign bus.out_x      = out_x;
    assign bus.out_y      = out_y;
    assign bus.xfer_count = xfer_count_q;

endmodule

// File: tb/tb_compc_arbiter.sv
// Self-checking bench for compc_arbiter against a behavioural reference model.
module tb_compc_arbiter;

    localparam int DW = 8;
    localparam int MB = 4;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    compc_arbiter_if #(.DATA_W(DW)) bus();

    compc_arbiter #(.DATA_W(DW), .MAX_BURST(MB)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: who owns the path, how long the current streak is,
    // who goes first from idle, and the contents of the output slot.
    int          m_owner;
    int          m_streak;
    int          m_rr;
    bit          m_ov;
    bit          m_id;
    logic [7:0]  m_x, m_y;
    int unsigned m_cnt;

    bit obs_r0, obs_r1, exp_r0, exp_r1;

    task automatic model_reset();
        m_owner = -1; m_streak = 0; m_rr = 0;
        m_ov = 0; m_id = 0; m_x = '0; m_y = '0; m_cnt = 0;
    endtask

    function automatic int pick(bit v0, bit v1, bit ld);
        bit v[2];
        v[0] = v0; v[1] = v1;
        if (!ld) return -1;
        if (m_owner < 0) begin
            if (v0 && v1) return m_rr;
            if (v0) return 0;
            if (v1) return 1;
            return -1;
        end
        if (v[m_owner] && (m_streak < MB || !v[1-m_owner])) return m_owner;
        if (v[1-m_owner]) return 1 - m_owner;
        return -1;
    endfunction

    // Drive one cycle of stimulus, capture readies mid-cycle, advance the model.
    task automatic step(input bit v0, input logic [7:0] a0, input logic [7:0] b0,
                        input bit v1, input logic [7:0] a1, input logic [7:0] b1,
                        input bit ordy);
        int win;
        bit ld;
        bus.req0_valid = v0; bus.req0_a = a0; bus.req0_b = b0;
        bus.req1_valid = v1; bus.req1_a = a1; bus.req1_b = b1;
        bus.out_ready  = ordy;
        #2;
        ld  = !m_ov || ordy;
        win = pick(v0, v1, ld);
        obs_r0 = bus.req0_ready; obs_r1 = bus.req1_ready;
        exp_r0 = (win == 0);     exp_r1 = (win == 1);
        @(posedge clock);
        if (m_ov && ordy) m_cnt = (m_cnt + 1) % 65536;
        if (ld) begin
            if (win >= 0) begin
                m_streak = (win == m_owner) ? ((m_streak < MB) ? m_streak + 1 : MB) : 1;
                m_owner  = win;
            end else if (m_owner >= 0) begin
                m_rr = 1 - m_owner; m_owner = -1; m_streak = 0;
            end
        end
        if (win >= 0) begin
            m_ov = 1; m_id = (win == 1);
            m_x = (win == 1) ? a1 : a0;
            m_y = (win == 1) ? b1 : b0;
        end else if (ordy) begin
            m_ov = 0;
        end
        #1;
    endtask

    task automatic idle_inputs();
        bus.req0_valid = 0; bus.req0_a = '0; bus.req0_b = '0;
        bus.req1_valid = 0; bus.req1_a = '0; bus.req1_b = '0;
        bus.out_ready  = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.req0_valid = 1; bus.req1_valid = 1; bus.out_ready = 1;
        bus.req0_a = 8'h5A; bus.req0_b = 8'hA5; bus.req1_a = 8'h3C; bus.req1_b = 8'hC3;
        repeat (2) @(posedge clock);
        #3;
        checks++;
        if ({bus.req1_ready, bus.req0_ready} !== 2'b00) begin
            errors++; $display("FAIL reset_ready got=%b exp=00", {bus.req1_ready, bus.req0_ready});
        end
        checks++;
        if ({bus.out_valid, bus.out_id, bus.out_x, bus.out_y} !== 18'h0) begin
            errors++; $display("FAIL reset_out got=%h exp=0", {bus.out_valid, bus.out_id, bus.out_x, bus.out_y});
        end
        checks++;
        if (bus.xfer_count !== 16'h0) begin
            errors++; $display("FAIL reset_xfer got=%h exp=0000", bus.xfer_count);
        end
        do_reset();
    endtask

    task automatic test_streaming();
        do_reset();
        for (int k = 0; k < 6; k++) begin
            step(1, 8'(8'h11 + k), 8'(8'hA0 + k), 0, 8'h00, 8'h00, 1);
            checks++;
            if ({obs_r1, obs_r0} !== 2'b01) begin
                errors++; $display("FAIL stream_ready k=%0d got=%b exp=01", k, {obs_r1, obs_r0});
            end
            checks++;
            if ({bus.out_valid, bus.out_id, bus.out_x, bus.out_y} !== {1'b1, 1'b0, 8'(8'h11 + k), 8'(8'hA0 + k)}) begin
                errors++;
                $display("FAIL stream_out k=%0d got=%b/%b/%h/%h exp=1/0/%h/%h", k,
                         bus.out_valid, bus.out_id, bus.out_x, bus.out_y, 8'(8'h11 + k), 8'(8'hA0 + k));
            end
        end
        step(0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 1);
        checks++;
        if (bus.xfer_count !== 16'd6) begin
            errors++; $display("FAIL stream_xfer got=%0d exp=6", bus.xfer_count);
        end
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL stream_drain got=%b exp=0", bus.out_valid);
        end
    endtask

    task automatic test_burst_cap();
        logic [7:0] pa[2], pb[2];
        do_reset();
        for (int i = 0; i < 2; i++) begin pa[i] = 8'($urandom); pb[i] = 8'($urandom); end
        for (int k = 0; k < 16; k++) begin
            step(1, pa[0], pb[0], 1, pa[1], pb[1], 1);
            checks++;
            if (bus.out_id !== 1'((k / MB) % 2) || bus.out_valid !== 1'b1) begin
                errors++; $display("FAIL burst_id k=%0d got=%b exp=%0d", k, bus.out_id, (k / MB) % 2);
            end
            checks++;
            if ({bus.out_x, bus.out_y} !== {m_x, m_y}) begin
                errors++; $display("FAIL burst_data k=%0d got=%h exp=%h", k, {bus.out_x, bus.out_y}, {m_x, m_y});
            end
            if (obs_r0) begin pa[0] = 8'($urandom); pb[0] = 8'($urandom); end
            if (obs_r1) begin pa[1] = 8'($urandom); pb[1] = 8'($urandom); end
        end
    endtask

    task automatic test_backpressure();
        logic [17:0]  held;
        int unsigned  cnt0;
        held = {m_ov, m_id, m_x, m_y};
        cnt0 = m_cnt;
        for (int k = 0; k < 3; k++) begin
            step(1, 8'h21, 8'h22, 1, 8'h31, 8'h32, 0);
            checks++;
            if ({obs_r1, obs_r0} !== 2'b00) begin
                errors++; $display("FAIL bp_ready k=%0d got=%b exp=00", k, {obs_r1, obs_r0});
            end
            checks++;
            if ({bus.out_valid, bus.out_id, bus.out_x, bus.out_y} !== held) begin
                errors++; $display("FAIL bp_hold k=%0d got=%h exp=%h", k,
                                   {bus.out_valid, bus.out_id, bus.out_x, bus.out_y}, held);
            end
        end
        step(1, 8'h21, 8'h22, 1, 8'h31, 8'h32, 1);
        checks++;
        if ((obs_r0 ^ obs_r1) !== 1'b1 || {obs_r1, obs_r0} !== {exp_r1, exp_r0}) begin
            errors++; $display("FAIL bp_release_ready got=%b exp=%b", {obs_r1, obs_r0}, {exp_r1, exp_r0});
        end
        checks++;
        if (bus.out_valid !== 1'b1 || {bus.out_id, bus.out_x, bus.out_y} !== {m_id, m_x, m_y}) begin
            errors++; $display("FAIL bp_reload got=%b/%h exp=1/%h", bus.out_valid,
                               {bus.out_id, bus.out_x, bus.out_y}, {m_id, m_x, m_y});
        end
        checks++;
        if (bus.xfer_count !== 16'((cnt0 + 1) % 65536)) begin
            errors++; $display("FAIL bp_xfer got=%0d exp=%0d", bus.xfer_count, (cnt0 + 1) % 65536);
        end
    endtask

    task automatic test_owner_drop();
        do_reset();
        step(0, 8'h00, 8'h00, 1, 8'h41, 8'h42, 1);
        checks++;
        if ({obs_r1, obs_r0} !== 2'b10) begin
            errors++; $display("FAIL drop_own1 got=%b exp=10", {obs_r1, obs_r0});
        end
        step(0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 1);
        step(1, 8'h51, 8'h52, 1, 8'h61, 8'h62, 1);
        checks++;
        if ({obs_r1, obs_r0} !== 2'b01) begin
            errors++; $display("FAIL drop_rr0 got=%b exp=01", {obs_r1, obs_r0});
        end
        checks++;
        if ({bus.out_id, bus.out_x, bus.out_y} !== {1'b0, 8'h51, 8'h52}) begin
            errors++; $display("FAIL drop_out0 got=%h exp=05152", {bus.out_id, bus.out_x, bus.out_y});
        end
        step(0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 1);
        step(1, 8'h71, 8'h72, 1, 8'h81, 8'h82, 1);
        checks++;
        if ({obs_r1, obs_r0} !== 2'b10) begin
            errors++; $display("FAIL drop_rr1 got=%b exp=10", {obs_r1, obs_r0});
        end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        step(1, 8'h91, 8'h92, 1, 8'hB1, 8'hB2, 1);
        step(1, 8'h93, 8'h94, 1, 8'hB1, 8'hB2, 1);
        bus.req0_a = 8'h95; bus.req0_b = 8'h96;
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({bus.out_valid, bus.out_id, bus.out_x, bus.out_y} !== 18'h0) begin
            errors++; $display("FAIL midrst_out got=%h exp=0", {bus.out_valid, bus.out_id, bus.out_x, bus.out_y});
        end
        checks++;
        if ({bus.req1_ready, bus.req0_ready} !== 2'b00) begin
            errors++; $display("FAIL midrst_ready got=%b exp=00", {bus.req1_ready, bus.req0_ready});
        end
        checks++;
        if (bus.xfer_count !== 16'h0) begin
            errors++; $display("FAIL midrst_xfer got=%h exp=0000", bus.xfer_count);
        end
        idle_inputs();
        model_reset();
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        step(1, 8'hC1, 8'hC2, 1, 8'hD1, 8'hD2, 1);
        checks++;
        if ({obs_r1, obs_r0} !== 2'b01) begin
            errors++; $display("FAIL midrst_first got=%b exp=01", {obs_r1, obs_r0});
        end
    endtask

    task automatic test_random();
        bit         pv[2];
        logic [7:0] pa[2], pb[2];
        bit         ordy;
        for (int i = 0; i < 2; i++) begin pv[i] = 0; pa[i] = '0; pb[i] = '0; end
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (!pv[i]) begin
                    pv[i] = ($urandom_range(0, 3) != 0);
                    pa[i] = 8'($urandom); pb[i] = 8'($urandom);
                end
            end
            ordy = ($urandom_range(0, 3) != 0);
            step(pv[0], pa[0], pb[0], pv[1], pa[1], pb[1], ordy);
            checks++;
            if ({obs_r1, obs_r0} !== {exp_r1, exp_r0}) begin
                errors++; $display("FAIL rand_ready c=%0d got=%b exp=%b", c, {obs_r1, obs_r0}, {exp_r1, exp_r0});
            end
            checks++;
            if ({bus.out_valid, bus.out_id, bus.out_x, bus.out_y} !== {m_ov, m_id, m_x, m_y}) begin
                errors++; $display("FAIL rand_out c=%0d got=%h exp=%h", c,
                                   {bus.out_valid, bus.out_id, bus.out_x, bus.out_y}, {m_ov, m_id, m_x, m_y});
            end
            checks++;
            if (bus.xfer_count !== 16'(m_cnt)) begin
                errors++; $display("FAIL rand_xfer c=%0d got=%0d exp=%0d", c, bus.xfer_count, m_cnt);
            end
            if (obs_r0) pv[0] = 0;
            if (obs_r1) pv[1] = 0;
        end
    endtask

    task automatic test_wrap();
        int guard;
        do_reset();
        guard = 0;
        while (m_cnt != 65535 && guard < 70000) begin
            step(1, 8'(guard), 8'(guard + 1), 0, 8'h00, 8'h00, 1);
            guard++;
        end
        checks++;
        if (bus.xfer_count !== 16'hFFFF) begin
            errors++; $display("FAIL wrap_max got=%h exp=ffff", bus.xfer_count);
        end
        step(1, 8'hEE, 8'hEF, 0, 8'h00, 8'h00, 1);
        checks++;
        if (bus.xfer_count !== 16'h0000) begin
            errors++; $display("FAIL wrap_zero got=%h exp=0000", bus.xfer_count);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle_inputs();
        reset = 1'b1;
        test_reset();
        test_streaming();
        test_burst_cap();
        test_backpressure();
        test_owner_drop();
        test_reset_mid_burst();
        test_random();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
